ctrl_edicion_fecha: RTL
=======================

Name: ctrl_edicion_fecha

Overview:
- Upstream edit controller for the date-setting counters (day, month, year).
- Takes raw push-button inputs, then synchronizes and debounces them.
- Runs an edit-mode FSM that selects which counter is being edited, and drives that counter's EN select and single-cycle aumento/disminuye pulses, with auto-repeat while a button is held.
- Outputs connect directly to the EN, aumento and disminuye inputs of the day/month/year counters.

Parameters:
- DEB_CYCLES, 16: consecutive cycles a synchronized button must differ from its debounced level before that level flips.
- REP_DELAY, 64: cycles a debounced up/down press must be held before auto-repeat starts.
- REP_PERIOD, 16: cycles between auto-repeat pulses.
- TIMEOUT, 4096: idle cycles in EDIT with no debounced press before a forced return to IDLE.
- N_FIELDS, 3: number of editable fields; EN runs 0..N_FIELDS-1 (0 = day, 1 = month, 2 = year).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- btn_edit  in  1  raw button; a press toggles edit mode.
- btn_up  in  1  raw button; increment.
- btn_down  in  1  raw button; decrement.
- btn_left  in  1  raw button; previous field.
- btn_right  in  1  raw button; next field.
- EN  out  2  field select to the counters; 2'd3 = no field selected.
- aumento  out  1  one-cycle increment pulse.
- disminuye  out  1  one-cycle decrement pulse.
- editing  out  1  high while the FSM is in EDIT.

Behaviour:
- Reset (rst low, asynchronous):
  - EN=2'd3; aumento=0; disminuye=0; editing=0.
  - State IDLE; debounced levels 0; all counters cleared.
  - Reset asserted mid-edit aborts immediately, with no pulse emitted.
- Input conditioning, per button:
  - 2-FF synchronizer, then debouncer.
  - Debounce counter counts while the synchronized level differs from the debounced level, and clears when they match.
  - At DEB_CYCLES the debounced level takes the new value and the counter clears.
  - "Press" = rising edge of the debounced level (one cycle).
- Latency: a raw rising edge held stable produces the aumento/disminuye pulse exactly DEB_CYCLES+3 clocks after the first edge that samples it high.
- FSM, IDLE:
  - EN=3, editing=0, no pulses.
  - btn_edit press -> EDIT with EN=0.
  - All other presses ignored.
- FSM, EDIT:
  - editing=1.
  - btn_edit press -> IDLE, EN=3.
  - btn_right press -> EN=(EN==N_FIELDS-1)?0:EN+1.
  - btn_left press -> EN=(EN==0)?N_FIELDS-1:EN-1.
  - Timeout counter clears on any press; reaching TIMEOUT -> IDLE, EN=3.
- Priority within one cycle: edit > left/right > up/down.
  - A field change or exit in a cycle suppresses any up/down pulse in that cycle.
  - It also clears the repeat counter.
  - left and right pressed in the same cycle: EN unchanged.
- Up/down pulse generation (EDIT only):
  - Press of up (down not held) -> aumento=1 for one cycle, registered the cycle after the press.
  - Down (up not held) -> disminuye=1 for one cycle, same timing.
  - Held after the press: hold counter runs; first repeat pulse REP_DELAY cycles after the initial pulse, then one every REP_PERIOD cycles while held.
  - Release clears the hold counter.
  - Up and down both debounced-high: no pulses; hold counter held at 0.
  - Releasing one of them does not create a pulse; a fresh press is required.
  - aumento and disminuye are never high together and never high outside EDIT.
- Pulse width: exactly 1 clock; the next pulse is at least REP_PERIOD (≥2) cycles later.
- Timeout counter saturates; it is not incremented outside EDIT.
- Counter widths: sized for the parameter values; no wrap-around of the debounce, hold or timeout counters before their terminal count.

Test Plan:
(bench parameters: DEB_CYCLES=4, REP_DELAY=20, REP_PERIOD=5, TIMEOUT=200)
- Reset/entry: release rst, hold btn_edit high for 10 clocks -> EN goes 3->0 and editing goes 0->1 at clock 7. Assert rst low mid-edit -> EN=3 and editing=0 immediately.
- Bounce rejection: btn_up toggling every 2 clocks for 30 clocks, then stable high -> exactly one aumento pulse, 7 clocks after the stable high starts; EN stays 0.
- Auto-repeat: in EDIT hold btn_down for 60 clocks after debounce -> disminuye pulses at t0, t0+20, t0+25, t0+30, ..., t0+55 (9 pulses); no aumento.
- Field wrap: EDIT at EN=0, press btn_left -> EN=2; press btn_right twice -> EN=0 then 1. Hold up and right together -> EN increments, no aumento in that cycle.
- Conflict: hold up and down together for 50 clocks -> zero pulses. Release down -> still zero until up is re-pressed.
- Timeout: enter EDIT and apply no presses for 200 clocks -> EN=3 and editing=0 at clock 200. A btn_up press at clock 150 restarts the count, so exit is at clock 350.

Source files
------------

// File: rtl/ctrl_edicion_fecha.sv
// Date-edit controller: debounces five push-buttons and drives the day/month/year
// counters' field select (EN) plus one-cycle increment/decrement pulses with auto-repeat.
module ctrl_edicion_fecha #(
  parameter int DEB_CYCLES = 16,
  parameter int REP_DELAY  = 64,
  parameter int REP_PERIOD = 16,
  parameter int TIMEOUT    = 4096,
  parameter int N_FIELDS   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_edit,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic [1:0] EN,
  output logic       aumento,
  output logic       disminuye,
  output logic       editing
);

  localparam int B_EDIT  = 0;
  localparam int B_UP    = 1;
  localparam int B_DOWN  = 2;
  localparam int B_LEFT  = 3;
  localparam int B_RIGHT = 4;
  localparam int NB      = 5;

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int HW = $clog2(REP_DELAY + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] LAST = 2'(N_FIELDS - 1);
  localparam logic [1:0] NONE = 2'd3;

  logic [NB-1:0] raw;
  logic [NB-1:0] deb;
  logic [NB-1:0] deb_prev;
  logic [NB-1:0] press;

  assign raw = {btn_right, btn_left, btn_down, btn_up, btn_edit};

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_btn
      logic          sync1;
      logic          sync2;
      logic          level;
      logic [DW-1:0] cnt;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          sync1 <= 1'b0;
          sync2 <= 1'b0;
          level <= 1'b0;
          cnt   <= '0;
        end else begin
          sync1 <= raw[gi];
          sync2 <= sync1;
          if (sync2 == level) begin
            cnt <= '0;
          end else if (cnt == DW'(DEB_CYCLES - 1)) begin
            level <= sync2;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      end

      assign deb[gi] = level;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) deb_prev <= '0;
    else      deb_prev <= deb;
  end

  assign press = deb & ~deb_prev;

  typedef enum logic {S_IDLE, S_EDIT} state_t;

  state_t        state;
  logic [TW-1:0] to_cnt;
  logic [TW-1:0] to_next;
  logic          timeout_hit;
  logic [HW-1:0] hold_cnt;
  logic          rep_arm;
  logic          rep_dn;

  // Any debounced press restarts the idle timer; it saturates at its terminal count.
  always_comb begin
    to_next = to_cnt;
    if (|press)                         to_next = '0;
    else if (to_cnt != TW'(TIMEOUT))    to_next = to_cnt + 1'b1;
    timeout_hit = (to_next == TW'(TIMEOUT));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      EN        <= NONE;
      editing   <= 1'b0;
      aumento   <= 1'b0;
      disminuye <= 1'b0;
      to_cnt    <= '0;
      hold_cnt  <= '0;
      rep_arm   <= 1'b0;
      rep_dn    <= 1'b0;
    end else begin
      aumento   <= 1'b0;
      disminuye <= 1'b0;
      case (state)
        S_IDLE: begin
          to_cnt   <= '0;
          hold_cnt <= '0;
          rep_arm  <= 1'b0;
          if (press[B_EDIT]) begin
            state   <= S_EDIT;
            EN      <= 2'd0;
            editing <= 1'b1;
          end
        end
        S_EDIT: begin
          to_cnt <= to_next;
          if (press[B_EDIT] || timeout_hit) begin
            state    <= S_IDLE;
            EN       <= NONE;
            editing  <= 1'b0;
            to_cnt   <= '0;
            hold_cnt <= '0;
            rep_arm  <= 1'b0;
          end else if (press[B_LEFT] || press[B_RIGHT]) begin
            hold_cnt <= '0;
            rep_arm  <= 1'b0;
            if (press[B_RIGHT] && !press[B_LEFT])
              EN <= (EN == LAST) ? 2'd0 : EN + 2'd1;
            else if (press[B_LEFT] && !press[B_RIGHT])
              EN <= (EN == 2'd0) ? LAST : EN - 2'd1;
          end else if (deb[B_UP] && deb[B_DOWN]) begin
            // Conflicting hold disarms repeat; only a fresh press re-arms it.
            hold_cnt <= '0;
            rep_arm  <= 1'b0;
          end else if (press[B_UP]) begin
            aumento  <= 1'b1;
            rep_arm  <= 1'b1;
            rep_dn   <= 1'b0;
            hold_cnt <= '0;
          end else if (press[B_DOWN]) begin
            disminuye <= 1'b1;
            rep_arm   <= 1'b1;
            rep_dn    <= 1'b1;
            hold_cnt  <= '0;
          end else if (rep_arm && (rep_dn ? deb[B_DOWN] : deb[B_UP])) begin
            if (hold_cnt == HW'(REP_DELAY - 1)) begin
              aumento   <= ~rep_dn;
              disminuye <= rep_dn;
              hold_cnt  <= HW'(REP_DELAY - REP_PERIOD);
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end else begin
            hold_cnt <= '0;
            rep_arm  <= 1'b0;
          end
        end
        default: begin
          state   <= S_IDLE;
          EN      <= NONE;
          editing <= 1'b0;
        end
      endcase
    end
  end

endmodule
